alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Multi-cycle control/issue unit that fetches 32-bit instructions, decodes them and drives the ALU control inputs: opcode, condition, S, shift/rotate control, shift amount and immediate.
- Sequences register-file reads, ALU execute, optional data-memory access and register writeback.
- Keeps the architectural flags register.
- Sits between instruction memory, the register file and the ALU.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, PC increment per retired or skipped instruction.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_valid  in  1  instruction data valid
- imem_data  in  32  instruction word
- alu_opcode  out  4  to ALU Opcode
- alu_cond  out  4  to ALU Cond
- alu_s  out  1  to ALU S
- alu_sr_cont  out  3  to ALU SR_Cont
- alu_sr_bit  out  5  to ALU SR_Bit
- alu_imm  out  16  to ALU Immediate
- alu_cond_met  in  1  from ALU Condition_met
- alu_flags  in  4  from ALU Flags (N,Z,C,V)
- rf_raddr1  out  4  register file read port 1 (rn, feeds In1)
- rf_raddr2  out  4  register file read port 2 (rm, feeds In2)
- rf_waddr  out  4  writeback register (rd)
- rf_we  out  1  writeback strobe, one cycle
- dmem_req  out  1  data memory request (LDR/STR)
- dmem_we  out  1  1 = store
- dmem_ack  in  1  data memory done
- flags_q  out  4  architectural flags register
- pc  out  32  current PC
- busy  out  1  high in every state except IDLE

Behaviour:
- Instruction fields: [31:28] cond, [27:24] opcode, [23] S, [22:20] sr_cont, [19:16] rd, [15:12] rn, [11:8] rm, [7:3] sr_bit, [2:0] reserved.
- alu_imm = instr[15:0] for every opcode; the ALU uses it only for MOVI.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 MUL, 0011 OR, 0100 AND, 0101 XOR
  - 0110 MOVI, 0111 MOV
  - 1011 CMP, 1101 LDR, 1110 STR, 1111 NOP
  - Any other opcode is treated as STR, matching the ALU default case.
- Reset values: pc = RESET_PC, flags_q = 0, instr register = 32'hF000_0000 (NOP), FSM = IDLE. imem_req, rf_we, dmem_req, dmem_we and busy are 0. All alu_* outputs are driven from the instr register, so they reset to the NOP fields.
- FSM: IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> WB -> FETCH.
  - IDLE: one cycle after reset release, then go to FETCH.
  - FETCH: hold imem_req = 1 and imem_addr = pc until imem_valid. On the imem_valid cycle, latch imem_data into the instr register and go to DECODE. imem_valid outside FETCH is ignored.
  - DECODE: rf_raddr1/2 are presented from the latched instr. One cycle, to allow the synchronous register-file read.
  - EXEC: sample alu_cond_met into cond_q.
    - Flags update: if cond_met and ((S = 1 and opcode in 0000..0101) or opcode = 1011), then flags_q <= alu_flags at the end of EXEC.
    - If cond_met and opcode is LDR/STR, go to MEM; otherwise go to WB.
  - MEM: hold dmem_req = 1, with dmem_we = 1 for STR, until dmem_ack, then go to WB. If dmem_ack arrives in the same cycle MEM is entered, the handshake completes that cycle.
  - WB: rf_we = 1 for one cycle when cond_q = 1 and the opcode is one of ADD..XOR, MOVI, MOV or LDR. rf_waddr = rd. pc <= pc + PC_STEP, then go to FETCH.
- NOP (1111): no flag update, no writeback, no memory access; the PC still advances.
- Failed condition: the instruction is skipped with no side effects except the PC advance; latency is unchanged minus MEM.
- Latency in cycles from imem_valid to next imem_req: 3 for ALU ops (DECODE, EXEC, WB); 3 + n for memory ops, where n ≥ 1 is the number of MEM cycles.
- pc wraps modulo 2^32 with no error.
- Asynchronous reset mid-operation: any outstanding imem/dmem request is abandoned immediately, all registers return to reset values, and a late ack is ignored.

Optional Feature:
- Macro: ALU_ISSUE_HALT_EN.
- When defined:
  - Opcode 1111 with instr[0] = 1 is HALT. WB goes to a HALT state instead of FETCH; pc is not advanced and busy is 0.
  - Only rst leaves HALT.
  - Adds output port halted (1 bit, reset 0, 1 in HALT).
- When undefined: every 1111 is a NOP, and the halted port and HALT state do not exist.

Test Plan:
- Reset then fetch: rst pulse, imem_valid held 1 -> imem_addr = 0, then 4, then 8; busy rises 1 cycle after reset release.
- ADDS with cond 0000, S = 1, rd = 3, ALU flags 4'b0100 -> rf_we pulse in WB with rf_waddr = 3; flags_q = 4'b0100 after EXEC. Same instruction with S = 0 -> flags_q unchanged.
- CMP with alu_flags = 4'b1000 -> flags_q = 4'b1000, no rf_we, no dmem_req.
- SUB with cond 0001 and alu_cond_met = 0 -> no rf_we, no flag change; pc advances by 4 after 3 cycles.
- LDR rd = 5, dmem_ack delayed 3 cycles -> dmem_req high exactly 3 cycles with dmem_we = 0, then rf_we with rf_waddr = 5. STR -> dmem_we = 1, no rf_we.
- rst asserted during MEM -> dmem_req drops in the same cycle, pc = RESET_PC, flags_q = 0. With ALU_ISSUE_HALT_EN: instr 32'hFF00_0001 -> halted = 1 and no further imem_req.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - multi-cycle fetch/decode/issue controller driving the ALU, register file and data memory
//
// Purpose: fetches 32-bit instructions, presents the decoded fields to the ALU,
// sequences register reads, execute, optional data-memory access and writeback,
// and holds the architectural N,Z,C,V flags.
//
// Optional feature macro: ALU_ISSUE_HALT_EN (opcode 1111 with instr[0] = 1 halts,
// adds the halted output).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req/addr/valid/data instruction fetch handshake
//   alu_opcode/cond/s/sr_cont/sr_bit/imm  ALU control fields from instr register
//   alu_cond_met, alu_flags  ALU status inputs sampled in EXEC
//   rf_raddr1/2, rf_waddr, rf_we  register file control
//   dmem_req/we/ack          data memory handshake
//   flags_q, pc, busy        architectural state and activity
//   halted                   HALT state indicator (ALU_ISSUE_HALT_EN only)
module alu_issue_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  output logic [3:0]  alu_opcode,
  output logic [3:0]  alu_cond,
  output logic        alu_s,
  output logic [2:0]  alu_sr_cont,
  output logic [4:0]  alu_sr_bit,
  output logic [15:0] alu_imm,
  input  logic        alu_cond_met,
  input  logic [3:0]  alu_flags,
  output logic [3:0]  rf_raddr1,
  output logic [3:0]  rf_raddr2,
  output logic [3:0]  rf_waddr,
  output logic        rf_we,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic [3:0]  flags_q,
  output logic [31:0] pc,
  output logic        busy
`ifdef ALU_ISSUE_HALT_EN
  ,
  output logic        halted
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
`ifdef ALU_ISSUE_HALT_EN
    ,
    S_HALT   = 3'd6
`endif
  } state_t;

  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_MOV = 4'b0111;
  localparam logic [3:0] OP_CMP = 4'b1011;
  localparam logic [3:0] OP_LDR = 4'b1101;
  localparam logic [3:0] OP_NOP = 4'b1111;

  state_t      state, state_d;
  logic [31:0] instr;
  logic        cond_q;
  logic [3:0]  opc;
  logic        is_ldr;
  logic        is_mem;
  logic        wr_rd;
  logic        flag_upd;
  logic        halt_op;
  logic        unused_bits;

  assign opc      = instr[27:24];
  assign is_ldr   = (opc == OP_LDR);
  // Everything that is not an ALU op, MOV/MOVI, CMP or NOP is a memory op;
  // undefined opcodes behave as STR, like the ALU default case.
  assign is_mem   = (opc > OP_MOV) && (opc != OP_CMP) && (opc != OP_NOP);
  assign wr_rd    = (opc <= OP_MOV) || is_ldr;
  assign flag_upd = (instr[23] && (opc <= OP_XOR)) || (opc == OP_CMP);

`ifdef ALU_ISSUE_HALT_EN
  assign halt_op  = (opc == OP_NOP) && instr[0];
  assign halted   = (state == S_HALT);
`else
  assign halt_op  = 1'b0;
`endif
  assign unused_bits = ^instr[2:0];

  assign imem_addr   = pc;
  assign alu_cond    = instr[31:28];
  assign alu_opcode  = opc;
  assign alu_s       = instr[23];
  assign alu_sr_cont = instr[22:20];
  assign rf_waddr    = instr[19:16];
  assign rf_raddr1   = instr[15:12];
  assign rf_raddr2   = instr[11:8];
  assign alu_sr_bit  = instr[7:3];
  assign alu_imm     = instr[15:0];

`ifdef ALU_ISSUE_HALT_EN
  assign busy = (state != S_IDLE) && (state != S_HALT);
`else
  assign busy = (state != S_IDLE);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      flags_q <= 4'b0000;
      instr   <= 32'hF000_0000;
      cond_q  <= 1'b0;
    end else begin
      state <= state_d;
      if (state == S_FETCH && imem_valid) begin
        instr <= imem_data;
      end
      if (state == S_EXEC) begin
        cond_q <= alu_cond_met;
        if (alu_cond_met && flag_upd) begin
          flags_q <= alu_flags;
        end
      end
      // A halting instruction leaves pc pointing at itself.
      if (state == S_WB && !(cond_q && halt_op)) begin
        pc <= pc + 32'(PC_STEP);
      end
    end
  end

  always_comb begin
    state_d  = state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    case (state)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        // alu_cond_met is used live here; cond_q only exists for WB.
        if (alu_cond_met && is_mem) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = !is_ldr;
        if (dmem_ack) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we = cond_q && wr_rd;
`ifdef ALU_ISSUE_HALT_EN
        state_d = (cond_q && halt_op) ? S_HALT : S_FETCH;
`else
        state_d = S_FETCH;
`endif
      end
`ifdef ALU_ISSUE_HALT_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

endmodule
